// File: rtl/accum_sched_pkg.sv
// rtl/accum_sched_pkg.sv - state encoding and shared constants for accum_sched
package accum_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int STAT_W = 16;

endpackage

// File: rtl/accum_sched_if.sv
// rtl/accum_sched_if.sv - message/sum channel between the scheduler and the shared accumulator
interface accum_sched_if #(
  parameter int p_width = 4
);

  logic               acc_req_val;
  logic               acc_req_rdy;
  logic [p_width-1:0] acc_req_msg;
  logic               acc_resp_val;
  logic               acc_resp_rdy;
  logic [p_width-1:0] acc_resp_msg;

  modport master (
    output acc_req_val, acc_req_msg, acc_resp_rdy,
    input  acc_req_rdy, acc_resp_val, acc_resp_msg
  );

  modport slave (
    input  acc_req_val, acc_req_msg, acc_resp_rdy,
    output acc_req_rdy, acc_resp_val, acc_resp_msg
  );

endinterface

// File: rtl/accum_sched_rr_pick.sv
// rtl/accum_sched_rr_pick.sv - round-robin pick: first set req bit at or after ptr
module rr_pick #(
  parameter int p_n  = 4,
  parameter int p_iw = $clog2(p_n)
) (
  input  logic [p_n-1:0]  req,
  input  logic [p_iw-1:0] ptr,
  output logic [p_iw-1:0] grant,
  output logic            any
);

  int idx;

  // Scan from the farthest offset down so the nearest requester after ptr wins.
  always_comb begin
    grant = '0;
    idx   = 0;
    for (int i = p_n - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % p_n;
      if (req[idx]) grant = p_iw'(idx);
    end
  end

  assign any = |req;

endmodule

// File: rtl/accum_sched.sv
// rtl/accum_sched.sv - batch-locked round-robin scheduler in front of a shared accumulator
// Optional per-requester batch counters: ACCUM_SCHED_STATS_EN
module accum_sched
  import accum_sched_pkg::*;
#(
  parameter int p_width = 4,
  parameter int p_nmsgs = 4,
  parameter int p_nreqs = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [p_nreqs-1:0]           req_val,
  output logic [p_nreqs-1:0]           req_rdy,
  input  logic [p_nreqs*p_width-1:0]   req_msg,
  output logic [p_nreqs-1:0]           resp_val,
  input  logic [p_nreqs-1:0]           resp_rdy,
  output logic [p_width-1:0]           resp_msg,
  accum_sched_if.master                acc,
  output logic [$clog2(p_nreqs)-1:0]   owner,
  output logic                         busy
`ifdef ACCUM_SCHED_STATS_EN
  ,
  output logic [p_nreqs*STAT_W-1:0]    batch_cnt
`endif
);

  localparam int IW = $clog2(p_nreqs);
  localparam int CW = $clog2(p_nmsgs + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          req_fire;
  logic          resp_fire;

  rr_pick #(.p_n(p_nreqs)) u_pick (
    .req   (req_val),
    .ptr   (rr_ptr),
    .grant (pick_idx),
    .any   (pick_any)
  );

  assign req_fire  = acc.acc_req_val && acc.acc_req_rdy;
  assign resp_fire = acc.acc_resp_val && acc.acc_resp_rdy;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            owner <= pick_idx;
            state <= FEED;
          end
        end
        FEED: begin
          if (req_fire) begin
            if (cnt == CW'(p_nmsgs - 1)) begin
              cnt   <= '0;
              state <= WAIT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        WAIT: begin
          if (resp_fire) begin
            state  <= IDLE;
            rr_ptr <= (int'(owner) == p_nreqs - 1) ? '0 : owner + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake routing: only the owner's lane is connected, and only in its phase.
  always_comb begin
    req_rdy          = '0;
    resp_val         = '0;
    acc.acc_req_val  = 1'b0;
    acc.acc_resp_rdy = 1'b0;
    acc.acc_req_msg  = req_msg[int'(owner)*p_width +: p_width];
    resp_msg         = acc.acc_resp_msg;
    case (state)
      FEED: begin
        acc.acc_req_val = req_val[owner];
        req_rdy[owner]  = acc.acc_req_rdy;
      end
      WAIT: begin
        resp_val[owner]  = acc.acc_resp_val;
        acc.acc_resp_rdy = resp_rdy[owner];
      end
      default: ;
    endcase
  end

`ifdef ACCUM_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      batch_cnt <= '0;
    end else if (state == WAIT && resp_fire) begin
      batch_cnt[int'(owner)*STAT_W +: STAT_W] <= batch_cnt[int'(owner)*STAT_W +: STAT_W] + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_accum_sched.sv
// tb/tb_accum_sched.sv - scoreboard bench for accum_sched with a behavioural accumulator
// Exercises batch_cnt when ACCUM_SCHED_STATS_EN is defined
module tb_accum_sched;
  import accum_sched_pkg::*;

  localparam int W  = 4;
  localparam int NM = 4;
  localparam int NR = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_val;
  logic [NR-1:0]     req_rdy;
  logic [NR*W-1:0]   req_msg;
  logic [NR-1:0]     resp_val;
  logic [NR-1:0]     resp_rdy;
  logic [W-1:0]      resp_msg;
  logic [1:0]        owner;
  logic              busy;
`ifdef ACCUM_SCHED_STATS_EN
  logic [NR*STAT_W-1:0] batch_cnt;
`endif

  accum_sched_if #(.p_width(W)) acc ();

  accum_sched #(.p_width(W), .p_nmsgs(NM), .p_nreqs(NR)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_msg  (req_msg),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_msg (resp_msg),
    .acc      (acc),
    .owner    (owner),
    .busy     (busy)
`ifdef ACCUM_SCHED_STATS_EN
    ,
    .batch_cnt(batch_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int           idx;
    logic [W-1:0] val;
  } item_t;

  item_t        exp_acc_q[$];
  item_t        exp_resp_q[$];
  logic [W-1:0] rbuf[NR][64];
  int           head[NR];
  int           tail[NR];
  int           n_chk  = 0;
  int           n_pass = 0;
  logic         bp_mode = 1'b0;
  logic [NR-1:0] resp_rdy_cfg = '1;
  logic         acc_pending = 1'b0;
  logic [W-1:0] acc_sum = '0;
  logic [W-1:0] acc_out = '0;
  int           acc_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One cycle: drive at negedge, let it settle, then book the handshakes the next posedge commits.
  task automatic tick();
    item_t         e;
    logic [NR-1:0] hs;
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      req_val[i]         = (head[i] != tail[i]);
      req_msg[i*W +: W]  = rbuf[i][head[i] % 64];
    end
    acc.acc_req_rdy  = bp_mode ? ~acc.acc_req_rdy : 1'b1;
    acc.acc_resp_val = acc_pending;
    acc.acc_resp_msg = acc_out;
    resp_rdy         = resp_rdy_cfg;
    #1;
    if (reset) begin
      hs = req_val & req_rdy;
      if (acc.acc_req_val && acc.acc_req_rdy) begin
        if (exp_acc_q.size() == 0) begin
          check("acc_q_size", 32'(exp_acc_q.size()), 32'd1);
        end else begin
          e = exp_acc_q.pop_front();
          check("acc_msg", 32'(acc.acc_req_msg), 32'(e.val));
          check("req_hs", 32'(hs), 32'(1) << e.idx);
        end
        for (int i = 0; i < NR; i++) if (hs[i]) head[i]++;
        acc_sum = acc_sum + acc.acc_req_msg;
        acc_cnt++;
        if (acc_cnt == NM) begin
          acc_pending = 1'b1;
          acc_out     = acc_sum;
          acc_sum     = '0;
          acc_cnt     = 0;
        end
      end else if (hs != '0) begin
        check("req_hs_stray", 32'(hs), 32'd0);
      end
      if (acc.acc_resp_val && acc.acc_resp_rdy) begin
        acc_pending = 1'b0;
        if (exp_resp_q.size() == 0) begin
          check("resp_q_size", 32'(exp_resp_q.size()), 32'd1);
        end else begin
          e = exp_resp_q.pop_front();
          check("resp_msg", 32'(resp_msg), 32'(e.val));
          check("resp_val", 32'(resp_val), 32'(1) << e.idx);
          check("resp_owner", 32'(owner), 32'(e.idx));
        end
      end
    end
  endtask

  task automatic load_batch(input int r, input logic [W-1:0] base);
    for (int k = 0; k < NM; k++) begin
      rbuf[r][tail[r] % 64] = base + W'(k);
      tail[r]++;
    end
  endtask

  task automatic expect_batch(input int r, input logic [W-1:0] base, input int n_msgs, input bit with_resp);
    item_t        e;
    logic [W-1:0] s;
    s = '0;
    for (int k = 0; k < n_msgs; k++) begin
      e.idx = r;
      e.val = base + W'(k);
      s     = s + e.val;
      exp_acc_q.push_back(e);
    end
    if (with_resp) begin
      e.idx = r;
      e.val = s;
      exp_resp_q.push_back(e);
    end
  endtask

  task automatic flush();
    for (int i = 0; i < NR; i++) head[i] = tail[i];
    acc_pending = 1'b0;
    acc_sum     = '0;
    acc_cnt     = 0;
    exp_acc_q.delete();
    exp_resp_q.delete();
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_acc_q.size() != 0 || exp_resp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 32'(exp_acc_q.size() + exp_resp_q.size()), 32'd0);
    tick();
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_pending(input string tag, input int budget);
    int n;
    n = 0;
    while (!acc_pending && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_pending"}, 32'(acc_pending), 32'd1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_req_rdy"}, 32'(req_rdy), 32'd0);
    check({tag, "_resp_val"}, 32'(resp_val), 32'd0);
    check({tag, "_acc_req_val"}, 32'(acc.acc_req_val), 32'd0);
    check({tag, "_acc_resp_rdy"}, 32'(acc.acc_resp_rdy), 32'd0);
    check({tag, "_owner"}, 32'(owner), 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    reset            = 1'b0;
    req_val          = '0;
    req_msg          = '0;
    resp_rdy         = '1;
    acc.acc_req_rdy  = 1'b0;
    acc.acc_resp_val = 1'b0;
    acc.acc_resp_msg = '0;

    repeat (3) tick();
    check_quiet("rst");
    reset = 1'b1;

    // Single requester: 1+2+3+4 returns 10 to requester 0.
    load_batch(0, 4'd1);
    expect_batch(0, 4'd1, NM, 1'b1);
    run_until_idle("single", 50);

    // rr_ptr now points at 1, so requester 1 beats requester 0.
    load_batch(0, 4'd5);
    load_batch(1, 4'd9);
    expect_batch(1, 4'd9, NM, 1'b1);
    expect_batch(0, 4'd5, NM, 1'b1);
    run_until_idle("rrptr", 100);

    // Contention from reset: grant order 0,1,2,3,0.
    reset = 1'b0;
    flush();
    load_batch(0, 4'd1);
    load_batch(0, 4'd13);
    load_batch(1, 4'd4);
    load_batch(2, 4'd7);
    load_batch(3, 4'd10);
    repeat (2) tick();
    reset = 1'b1;
    expect_batch(0, 4'd1, NM, 1'b1);
    expect_batch(1, 4'd4, NM, 1'b1);
    expect_batch(2, 4'd7, NM, 1'b1);
    expect_batch(3, 4'd10, NM, 1'b1);
    expect_batch(0, 4'd13, NM, 1'b1);
    run_until_idle("contend", 200);

    // Accumulator backpressure toggling every cycle.
    bp_mode = 1'b1;
    load_batch(2, 4'd3);
    expect_batch(2, 4'd3, NM, 1'b1);
    wait_pending("bp", 40);
    tick();
    check("bp_wait_acc_req_val", 32'(acc.acc_req_val), 32'd0);
    check("bp_wait_busy", 32'(busy), 32'd1);
    bp_mode = 1'b0;
    run_until_idle("bp", 40);

    // Response stall on requester 2 while requester 0 is waiting.
    resp_rdy_cfg[2] = 1'b0;
    load_batch(2, 4'd6);
    expect_batch(2, 4'd6, NM, 1'b1);
    wait_pending("stall", 40);
    load_batch(0, 4'd2);
    expect_batch(0, 4'd2, NM, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_acc_resp_rdy", 32'(acc.acc_resp_rdy), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
      check("stall_req_rdy", 32'(req_rdy), 32'd0);
      check("stall_resp_val", 32'(resp_val), 32'b0100);
    end
    resp_rdy_cfg = '1;
    run_until_idle("stall", 60);

    // Reset after 2 of 4 messages from requester 3.
    load_batch(3, 4'd9);
    expect_batch(3, 4'd9, 2, 1'b0);
    n = 0;
    while (acc_cnt != 2 && n < 30) begin
      tick();
      n++;
    end
    check("mid_hs_cnt", 32'(acc_cnt), 32'd2);
    check("mid_acc_q", 32'(exp_acc_q.size()), 32'd0);
    reset = 1'b0;
    flush();
    repeat (2) tick();
    check_quiet("mid_rst");
    reset = 1'b1;
    tick();
    check_quiet("post_rst");
    load_batch(3, 4'd4);
    load_batch(0, 4'd8);
    expect_batch(0, 4'd8, NM, 1'b1);
    expect_batch(3, 4'd4, NM, 1'b1);
    run_until_idle("post_rst", 100);

`ifdef ACCUM_SCHED_STATS_EN
    reset = 1'b0;
    flush();
    repeat (2) tick();
    reset = 1'b1;
    for (int b = 0; b < 3; b++) begin
      load_batch(1, W'(3 * b));
      expect_batch(1, W'(3 * b), NM, 1'b1);
    end
    run_until_idle("stats", 150);
    for (int i = 0; i < NR; i++) begin
      check($sformatf("stats_cnt%0d", i), 32'(batch_cnt[i*STAT_W +: STAT_W]), (i == 1) ? 32'd3 : 32'd0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/accum_sched.md
ACCUM_SCHED -- requirements
Module: accum_sched

Interface
REQ-001 Parameter p_width, default 4: message and accumulation width in bits.
REQ-002 Parameter p_nmsgs, default 4: messages per accumulation batch, legal range 1..255.
REQ-003 Parameter p_nreqs, default 4: number of requester ports, legal range 2..8.
REQ-004 clk  in  1: single clock; all state updates on its rising edge.
REQ-005 reset  in  1: synchronous, active-low reset (asserted when 0).
REQ-006 req_val  in  p_nreqs: per-requester message valid.
REQ-007 req_rdy  out  p_nreqs: per-requester message ready.
REQ-008 req_msg  in  p_nreqs*p_width: flattened messages; requester i occupies bits [i*p_width +: p_width].
REQ-009 resp_val  out  p_nreqs: per-requester response valid.
REQ-010 resp_rdy  in  p_nreqs: per-requester response ready.
REQ-011 resp_msg  out  p_width: response data, shared by all requesters, meaningful only where resp_val is set.
REQ-012 acc_req_val / acc_req_rdy / acc_req_msg  out / in / out  1/1/p_width: message stream to the shared accumulator.
REQ-013 acc_resp_val / acc_resp_rdy / acc_resp_msg  in / out / in  1/1/p_width: sum returned by the shared accumulator.
REQ-014 owner  out  clog2(p_nreqs): index of the current grant holder.
REQ-015 busy  out  1: high whenever state is not IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, FEED and WAIT.
REQ-017 IDLE: if any req_val bit is set, the block SHALL latch owner as the first requester with req_val set, searching round-robin from rr_ptr, and SHALL move to FEED on the next cycle; no handshake occurs in IDLE.
REQ-018 FEED: acc_req_val = req_val[owner]; acc_req_msg = the owner's message slice; req_rdy[owner] = acc_req_rdy; all other req_rdy bits = 0.
REQ-019 FEED: the batch counter SHALL increment on each acc_req handshake; when the handshake that brings the count to p_nmsgs completes, the FSM SHALL move to WAIT and clear the counter.
REQ-020 WAIT: resp_val[owner] = acc_resp_val; resp_msg = acc_resp_msg; acc_resp_rdy = resp_rdy[owner]; every req_rdy bit = 0 and acc_req_val = 0.
REQ-021 WAIT: on the response handshake the FSM SHALL go to IDLE and set rr_ptr to (owner+1) mod p_nreqs.
REQ-022 Outside WAIT, all resp_val bits and acc_resp_rdy SHALL be 0; outside FEED, all req_rdy bits and acc_req_val SHALL be 0.
REQ-023 Grant is batch-locked: once granted, the owner is not preempted, even if other requesters are waiting or the owner deasserts req_val mid-batch.
REQ-024 Minimum batch time is 1 (arbitration) + p_nmsgs (feed) + 1 (response) cycles; a continuously requesting requester waits at most (p_nreqs-1) batches for its grant.
REQ-025 acc_resp_val arriving in IDLE or FEED is not consumed, because acc_resp_rdy is 0 there.
REQ-026 All datapath signals SHALL be pure muxes with no width change; the block performs no arithmetic on data.

Reset
REQ-027 While reset=0 at a clock edge: state=IDLE, counter=0, rr_ptr=0, owner=0.
REQ-028 Outputs SHALL be 0 during and after reset until the next grant: req_rdy, resp_val, acc_req_val, acc_resp_rdy and busy.
REQ-029 Reset asserted during FEED or WAIT SHALL abandon the batch without issuing a response.

Configuration
REQ-030 When ACCUM_SCHED_STATS_EN is defined, the block SHALL add an output batch_cnt of width p_nreqs*16, holding one 16-bit counter per requester.
REQ-031 Each batch_cnt counter SHALL increment on its requester's response handshake, wrap from 0xFFFF to 0, and be cleared by reset.
REQ-032 When ACCUM_SCHED_STATS_EN is undefined, the port and its counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-033 A shared package accum_sched_pkg SHALL hold the state enum (IDLE, FEED, WAIT) and the width constant for the stats counters (16).
REQ-034 Round-robin selection SHALL be a sub-module rr_pick: inputs req vector and ptr; outputs grant index and any-valid.

Verification
REQ-035 Single requester: req 0 sends 1,2,3,4 with p_nmsgs=4 and the accumulator returns 10 -> resp_val[0] with resp_msg=10, then IDLE with rr_ptr=1.
REQ-036 Contention: all four requesters valid from reset -> grants occur in order 0,1,2,3,0, with no interleaving of messages on acc_req.
REQ-037 Backpressure: acc_req_rdy toggles every cycle during FEED -> exactly 4 handshakes, no message duplicated or lost, WAIT entered after the 4th handshake.
REQ-038 Response stall: resp_rdy[2]=0 for 5 cycles in WAIT -> acc_resp_rdy held 0, state held in WAIT, no req_rdy asserted.
REQ-039 Reset mid-FEED after 2 of 4 messages -> after reset, state=IDLE, counter=0, rr_ptr=0 and all outputs 0.
REQ-040 With ACCUM_SCHED_STATS_EN defined: 3 batches from requester 1 -> batch_cnt slice 1 = 3 and all other slices = 0.
